capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register-bus data width.
REQ-002 SHALL have parameter FRAME_WIDTH, default 16, frame-counter width.
REQ-003 SHALL have parameter SCR_ADDR, default 0, sampler control-register address (3 bits).
REQ-004 SHALL have parameter FLOW_ADDR, default 1, sampler flow-length register address (3 bits).
REQ-005 SHALL have parameter TIMEOUT, default 1000000, maximum clk_i cycles spent waiting for start of frame.
REQ-006 SHALL have ports: clk_i in 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have ports: reset_i in 1, synchronous active-high reset.
REQ-008 SHALL have ports: start_i in 1, start pulse; stop_i in 1, abort pulse.
REQ-009 SHALL have ports: nb_frames_i in FRAME_WIDTH, number of frames to capture (0 = continuous); flowlength_i in DATA_WIDTH, pixels per frame.
REQ-010 SHALL have ports: addr_rel_o out 3, wr_o out 1, datawr_o out DATA_WIDTH, register-write master to the sampler.
REQ-011 SHALL have ports: in_dv in 1, in_sop in 1, in_eop in 1, monitored sampler stream flags.
REQ-012 SHALL have ports: busy_o out 1, done_o out 1, frame_cnt_o out FRAME_WIDTH, len_err_o out 1, timeout_o out 1.

Function
REQ-013 FSM states SHALL be IDLE, CFG_LEN, CFG_EN, WAIT_SOP, RUN, STOP, DONE.
REQ-014 IDLE: start_i=1 SHALL latch nb_frames_i and flowlength_i, clear frame_cnt_o, len_err_o, timeout_o, and go to CFG_LEN next cycle; stop_i ignored.
REQ-015 CFG_LEN: wr_o=1, addr_rel_o=FLOW_ADDR, datawr_o=latched flowlength for exactly one cycle, then CFG_EN.
REQ-016 CFG_EN: wr_o=1, addr_rel_o=SCR_ADDR, datawr_o=1 for exactly one cycle, then WAIT_SOP.
REQ-017 wr_o SHALL be 0 in every state except CFG_LEN, CFG_EN, STOP; addr_rel_o/datawr_o SHALL be 0 when wr_o=0.
REQ-018 WAIT_SOP: in_dv&in_sop SHALL load pixel counter with 1 and go to RUN; in_eop without in_sop ignored.
REQ-019 WAIT_SOP: timeout counter SHALL increment each cycle; on reaching TIMEOUT, set timeout_o (sticky) and go to STOP; counter cleared on entry to WAIT_SOP.
REQ-020 RUN: each in_dv cycle without sop SHALL increment pixel counter, saturating at all-ones.
REQ-021 in_dv&in_sop&in_eop same cycle (WAIT_SOP) SHALL count one-pixel frame, processed as REQ-022 in the following cycle-equivalent decision, no RUN residency required.
REQ-022 Frame end (in_dv&in_eop): frame_cnt_o SHALL increment (wrapping); if final pixel count != latched flowlength, set len_err_o (sticky); then STOP if nb_frames!=0 and new count == nb_frames, else WAIT_SOP.
REQ-023 RUN: in_dv&in_sop without preceding eop SHALL set len_err_o, not count a frame, and restart pixel counter at 1, remaining in RUN.
REQ-024 stop_i=1 in CFG_LEN, CFG_EN, WAIT_SOP or RUN SHALL go to STOP next cycle; a frame end in that same cycle still counts.
REQ-025 STOP: wr_o=1, addr_rel_o=SCR_ADDR, datawr_o=0 for one cycle, then DONE.
REQ-026 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-027 busy_o SHALL be 1 in every state except IDLE; start_i while busy ignored.
REQ-028 frame_cnt_o, len_err_o, timeout_o SHALL hold their values in IDLE until next accepted start_i.

Reset
REQ-029 reset_i=1 SHALL, at the next clk_i edge, force IDLE and all outputs to 0, regardless of state, with no STOP write issued.
REQ-030 Reset released mid-frame SHALL leave the block in IDLE ignoring stream flags until start_i.

Verification
REQ-031 nb_frames=2, flowlength=3200, start pulse, two clean 3200-pixel frames -> writes (1,3200),(0,1), frame_cnt_o=2, write (0,0), done_o one cycle, len_err_o=0.
REQ-032 flowlength=3200, frame with eop at pixel 3199 -> len_err_o=1, frame_cnt_o=1.
REQ-033 TIMEOUT=50, no sop after CFG_EN -> timeout_o=1 after 50 cycles in WAIT_SOP, STOP write (0,0), done_o.
REQ-034 nb_frames=0, three frames then stop_i -> frame_cnt_o=3, STOP write, done_o; start_i while busy ignored.
REQ-035 flowlength=1, sop&eop&dv same cycle -> frame_cnt_o=1, len_err_o=0.
REQ-036 reset_i asserted in RUN -> next cycle busy_o=0, wr_o=0, frame_cnt_o=0.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: programs the sampler flow length and enable, then follows the
// sop/eop stream to count frames and flag length errors, aborts and missing start-of-frame.
module capture_sequencer #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         FRAME_WIDTH = 16,
  parameter logic [2:0] SCR_ADDR    = 3'd0,
  parameter logic [2:0] FLOW_ADDR   = 3'd1,
  parameter int         TIMEOUT     = 1000000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [FRAME_WIDTH-1:0] nb_frames_i,
  input  logic [DATA_WIDTH-1:0]  flowlength_i,
  output logic [2:0]             addr_rel_o,
  output logic                   wr_o,
  output logic [DATA_WIDTH-1:0]  datawr_o,
  input  logic                   in_dv,
  input  logic                   in_sop,
  input  logic                   in_eop,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_WIDTH-1:0] frame_cnt_o,
  output logic                   len_err_o,
  output logic                   timeout_o
);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CFG_LEN, CFG_EN, WAIT_SOP, RUN, STOP, DONE} state_t;

  state_t                 r_state;
  logic [FRAME_WIDTH-1:0] r_nb;
  logic [DATA_WIDTH-1:0]  r_flow;
  logic [DATA_WIDTH-1:0]  r_pix;
  logic [TW-1:0]          r_to;

  state_t                 w_nxt;
  logic                   w_sop, w_eop, w_fend, w_last, w_timeout;
  logic [DATA_WIDTH-1:0]  w_pix_inc, w_fpix;
  logic [FRAME_WIDTH-1:0] w_frame_nxt;

  assign w_sop       = in_dv & in_sop;
  assign w_eop       = in_dv & in_eop;
  assign w_pix_inc   = (&r_pix) ? r_pix : r_pix + 1'b1;
  // A sop always restarts the count, so a sop+eop beat is a one-pixel frame.
  assign w_fpix      = w_sop ? DATA_WIDTH'(1) : w_pix_inc;
  assign w_fend      = ((r_state == WAIT_SOP) && w_sop && w_eop) || ((r_state == RUN) && w_eop);
  assign w_frame_nxt = frame_cnt_o + 1'b1;
  assign w_last      = (r_nb != '0) && (w_frame_nxt == r_nb);
  assign w_timeout   = (r_state == WAIT_SOP) && !stop_i && !w_sop && (r_to == TO_LAST);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     if (start_i) w_nxt = CFG_LEN;
      CFG_LEN:  w_nxt = stop_i ? STOP : CFG_EN;
      CFG_EN:   w_nxt = stop_i ? STOP : WAIT_SOP;
      WAIT_SOP, RUN: begin
        if (stop_i || (w_fend && w_last)) w_nxt = STOP;
        else if (w_fend)                  w_nxt = WAIT_SOP;
        else if (w_sop)                   w_nxt = RUN;
        else if (w_timeout)               w_nxt = STOP;
      end
      STOP:     w_nxt = DONE;
      DONE:     w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_nb        <= '0;
      r_flow      <= '0;
      r_pix       <= '0;
      r_to        <= '0;
      addr_rel_o  <= '0;
      wr_o        <= 1'b0;
      datawr_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_cnt_o <= '0;
      len_err_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      busy_o     <= (w_nxt != IDLE);
      done_o     <= (w_nxt == DONE);
      wr_o       <= 1'b0;
      addr_rel_o <= '0;
      datawr_o   <= '0;
      // Bus outputs are registered against the state being entered.
      case (w_nxt)
        CFG_LEN: begin wr_o <= 1'b1; addr_rel_o <= FLOW_ADDR; datawr_o <= flowlength_i; end
        CFG_EN:  begin wr_o <= 1'b1; addr_rel_o <= SCR_ADDR;  datawr_o <= DATA_WIDTH'(1); end
        STOP:    begin wr_o <= 1'b1; addr_rel_o <= SCR_ADDR;  datawr_o <= '0; end
        default: ;
      endcase

      if (r_state == IDLE && start_i) begin
        r_nb        <= nb_frames_i;
        r_flow      <= flowlength_i;
        frame_cnt_o <= '0;
        len_err_o   <= 1'b0;
        timeout_o   <= 1'b0;
      end

      if (w_nxt == WAIT_SOP && (r_state != WAIT_SOP || w_fend)) r_to <= '0;
      else if (r_state == WAIT_SOP)                            r_to <= r_to + 1'b1;

      if ((r_state == WAIT_SOP && w_sop) || (r_state == RUN && in_dv)) r_pix <= w_fpix;

      if (w_fend) begin
        frame_cnt_o <= w_frame_nxt;
        if (w_fpix != r_flow) len_err_o <= 1'b1;
      end
      if (r_state == RUN && w_sop) len_err_o <= 1'b1;
      if (w_timeout) timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus randomized runs predicted from
// frame-level rules (writes issued, frames counted, length mismatch, timeout).
module tb_capture_sequencer;
  localparam int DW = 32, FW = 16, TO = 50;

  logic          clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, stop_i = 1'b0;
  logic          in_dv = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [FW-1:0] nb_frames_i = '0;
  logic [DW-1:0] flowlength_i = '0;
  logic [2:0]    addr_rel_o;
  logic          wr_o, busy_o, done_o, len_err_o, timeout_o;
  logic [DW-1:0] datawr_o;
  logic [FW-1:0] frame_cnt_o;

  int          ncmp = 0, nfail = 0;
  logic [34:0] wq[$];
  int          done_n = 0, viol = 0;
  logic        done_d = 1'b0;

  always #5 clk_i = ~clk_i;

  capture_sequencer #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .SCR_ADDR(3'd0),
                      .FLOW_ADDR(3'd1), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .nb_frames_i(nb_frames_i), .flowlength_i(flowlength_i),
    .addr_rel_o(addr_rel_o), .wr_o(wr_o), .datawr_o(datawr_o),
    .in_dv(in_dv), .in_sop(in_sop), .in_eop(in_eop),
    .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o),
    .len_err_o(len_err_o), .timeout_o(timeout_o));

  // Bus monitor: logs writes, flags idle-bus garbage and done pulses longer than one cycle.
  always @(negedge clk_i) begin
    if (wr_o) wq.push_back({addr_rel_o, datawr_o});
    else if (addr_rel_o != 3'd0 || datawr_o != '0) viol <= viol + 1;
    if (done_o) begin
      done_n <= done_n + 1;
      if (done_d) viol <= viol + 1;
    end
    done_d <= done_o;
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(string tag, int nb, int flow);
    wq.delete();
    done_n = 0;
    nb_frames_i = FW'(nb); flowlength_i = DW'(flow); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    nb_frames_i = FW'($urandom); flowlength_i = DW'($urandom);
    chk({tag, "_cfglen"}, 64'({wr_o, addr_rel_o, datawr_o}), 64'({1'b1, 3'd1, DW'(flow)}));
    tick();
    chk({tag, "_cfgen"}, 64'({wr_o, addr_rel_o, datawr_o}), 64'({1'b1, 3'd0, DW'(1)}));
    tick();
    chk({tag, "_busy"}, 64'({busy_o, wr_o}), 64'(2'b10));
  endtask

  task automatic send_frame(int len, bit stop_at_eop, bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0) begin
          in_dv = 1'b0; in_sop = 1'($urandom_range(0, 1)); in_eop = 1'($urandom_range(0, 1));
          stop_i = 1'b0;
          tick();
        end
      in_dv = 1'b1; in_sop = (i == 0); in_eop = (i == len - 1);
      stop_i = stop_at_eop && (i == len - 1);
      tick();
    end
    in_dv = 1'b0; in_sop = 1'b0; in_eop = 1'b0; stop_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (done_n == 0 && n < 200) begin tick(); n++; end
    tick(); tick();
    chk({tag, "_done1"}, 64'(done_n), 64'(1));
    chk({tag, "_idle"}, 64'(busy_o), 64'(0));
  endtask

  task automatic chk_run(string tag, int flow, int frames, bit err, bit to);
    logic [34:0] exp [3];
    exp[0] = {3'd1, DW'(flow)}; exp[1] = {3'd0, DW'(1)}; exp[2] = {3'd0, DW'(0)};
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(3));
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_wr%0d", tag, k), 64'((k < wq.size()) ? wq[k] : {35{1'b1}}), 64'(exp[k]));
    chk({tag, "_frames"}, 64'(frame_cnt_o), 64'(frames));
    chk({tag, "_lenerr"}, 64'(len_err_o), 64'(err));
    chk({tag, "_timeout"}, 64'(timeout_o), 64'(to));
  endtask

  initial begin
    int t_to, t_dn;
    repeat (3) tick();
    chk("reset_state", 64'({busy_o, done_o, wr_o, addr_rel_o, datawr_o, frame_cnt_o, len_err_o, timeout_o}), 64'(0));
    reset_i = 1'b0;
    tick();

    // Two clean 3200-pixel frames
    do_start("two_frames", 2, 3200);
    send_frame(3200, 1'b0, 1'b0);
    chk("two_frames_mid", 64'({busy_o, frame_cnt_o}), 64'({1'b1, FW'(1)}));
    send_frame(3200, 1'b0, 1'b0);
    wait_done("two_frames");
    chk_run("two_frames", 3200, 2, 1'b0, 1'b0);

    // Status holds in IDLE while the stream keeps toggling
    for (int i = 0; i < 6; i++) begin
      in_dv = 1'($urandom_range(0, 1)); in_sop = 1'($urandom_range(0, 1)); in_eop = 1'($urandom_range(0, 1));
      tick();
    end
    in_dv = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    chk("idle_hold", 64'({busy_o, frame_cnt_o, len_err_o}), 64'({1'b0, FW'(2), 1'b0}));

    // Short frame
    do_start("short", 1, 3200);
    send_frame(3199, 1'b0, 1'b0);
    wait_done("short");
    chk_run("short", 3200, 1, 1'b1, 1'b0);

    // No sop: timeout after exactly TO cycles in WAIT_SOP
    do_start("tmo", 1, 7);
    t_to = -1; t_dn = -1;
    for (int k = 1; k <= 100 && t_dn < 0; k++) begin
      tick();
      if (timeout_o && t_to < 0) t_to = k;
      if (done_o && t_dn < 0) t_dn = k;
    end
    chk("tmo_flag_cycle", 64'(t_to), 64'(TO));
    chk("tmo_done_cycle", 64'(t_dn), 64'(TO + 1));
    tick(); tick();
    chk_run("tmo", 7, 0, 1'b0, 1'b1);

    // One-pixel frame: sop, eop, dv together
    do_start("onepix", 1, 1);
    send_frame(1, 1'b0, 1'b0);
    wait_done("onepix");
    chk_run("onepix", 1, 1, 1'b0, 1'b0);

    // Sop without preceding eop: error, no frame for the aborted fragment
    do_start("resop", 1, 5);
    in_dv = 1'b1; in_sop = 1'b1; tick();
    in_sop = 1'b0; tick(); tick();
    send_frame(5, 1'b0, 1'b0);
    wait_done("resop");
    chk_run("resop", 5, 1, 1'b1, 1'b0);

    // Continuous mode, start while busy ignored, stop ends it
    do_start("cont", 0, 4);
    for (int f = 0; f < 3; f++) begin
      send_frame(4, 1'b0, 1'b1);
      start_i = 1'b1; tick(); start_i = 1'b0;
    end
    pulse_stop();
    wait_done("cont");
    chk_run("cont", 4, 3, 1'b0, 1'b0);

    // Randomized runs checked against frame-level expectations
    for (int r = 0; r < 8; r++) begin
      int flow, nfr, nb, len;
      bit use_stop, bad, stopped, sae;
      flow = $urandom_range(1, 12);
      nfr = $urandom_range(1, 4);
      use_stop = ($urandom_range(0, 2) == 0);
      nb = use_stop ? 0 : nfr;
      bad = 1'b0; stopped = 1'b0;
      do_start($sformatf("rnd%0d", r), nb, flow);
      for (int f = 0; f < nfr; f++) begin
        len = flow;
        case ($urandom_range(0, 3))
          0: len = flow + 1;
          1: len = (flow > 1) ? flow - 1 : flow + 2;
          default: ;
        endcase
        if (len != flow) bad = 1'b1;
        sae = use_stop && (f == nfr - 1) && ($urandom_range(0, 1) == 1);
        if (sae) stopped = 1'b1;
        send_frame(len, sae, 1'b1);
        if (f != nfr - 1) begin
          repeat ($urandom_range(0, 3)) tick();
          if ($urandom_range(0, 1) == 1) begin start_i = 1'b1; tick(); start_i = 1'b0; end
        end
      end
      if (use_stop && !stopped) begin tick(); pulse_stop(); end
      wait_done($sformatf("rnd%0d", r));
      chk_run($sformatf("rnd%0d", r), flow, nfr, bad, 1'b0);
    end

    // Reset in RUN: immediate IDLE, cleared outputs, no STOP write, stream then ignored
    do_start("rst", 3, 6);
    send_frame(5, 1'b0, 1'b0);
    in_dv = 1'b1; in_sop = 1'b1; tick();
    in_sop = 1'b0; tick();
    chk("rst_pre", 64'({busy_o, frame_cnt_o, len_err_o}), 64'({1'b1, FW'(1), 1'b1}));
    reset_i = 1'b1; tick();
    chk("rst_now", 64'({busy_o, wr_o, done_o, frame_cnt_o, len_err_o, timeout_o}), 64'(0));
    reset_i = 1'b0;
    in_dv = 1'b1; tick(); in_eop = 1'b1; tick(); in_eop = 1'b0;
    send_frame(6, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_after", 64'({busy_o, frame_cnt_o, len_err_o}), 64'(0));
    chk("rst_nwr", 64'(wq.size()), 64'(2));

    chk("bus_violations", 64'(viol), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
